rotor_0: RTL and testbench

Rotor stage 0 of the Enigma cipher datapath. Substitutes one letter code (0–25, A–Z) through the fixed historical Rotor I wiring, offset by the current rotor position. The result is registered. It sits between the plugboard/entry stage and rotor stage 1. Position stepping is owned by the upstream stepping controller; this block only consumes `position`.

---
 rtl/rotor_0.sv | 119 +++++++++++
 tb/tb_rotor_0.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rotor_0.sv
// Enigma rotor stage 0: Rotor I substitution offset by position; ROTOR0_REVERSE_EN adds the inverse path.
// Latency: 1 cycle, with the output registered.
// Backpressure: none; accepts one sample per cycle, and data_out holds while in_valid is low.
module rotor_0 (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [4:0] data_in,
   input  logic [4:0] position,
`ifdef ROTOR0_REVERSE_EN
   input  logic       reverse,
`endif
   output logic       out_valid,
   output logic [4:0] data_out
);

   function automatic logic [4:0] fwd_tbl(input logic [5:0] i);
      case (i)
         6'd0:  fwd_tbl = 5'd4;
         6'd1:  fwd_tbl = 5'd10;
         6'd2:  fwd_tbl = 5'd12;
         6'd3:  fwd_tbl = 5'd5;
         6'd4:  fwd_tbl = 5'd11;
         6'd5:  fwd_tbl = 5'd6;
         6'd6:  fwd_tbl = 5'd3;
         6'd7:  fwd_tbl = 5'd16;
         6'd8:  fwd_tbl = 5'd21;
         6'd9:  fwd_tbl = 5'd25;
         6'd10: fwd_tbl = 5'd13;
         6'd11: fwd_tbl = 5'd19;
         6'd12: fwd_tbl = 5'd14;
         6'd13: fwd_tbl = 5'd22;
         6'd14: fwd_tbl = 5'd24;
         6'd15: fwd_tbl = 5'd7;
         6'd16: fwd_tbl = 5'd23;
         6'd17: fwd_tbl = 5'd20;
         6'd18: fwd_tbl = 5'd18;
         6'd19: fwd_tbl = 5'd15;
         6'd20: fwd_tbl = 5'd0;
         6'd21: fwd_tbl = 5'd8;
         6'd22: fwd_tbl = 5'd1;
         6'd23: fwd_tbl = 5'd17;
         6'd24: fwd_tbl = 5'd2;
         6'd25: fwd_tbl = 5'd9;
         default: fwd_tbl = 5'd0;
      endcase
   endfunction

`ifdef ROTOR0_REVERSE_EN
   function automatic logic [4:0] inv_tbl(input logic [5:0] i);
      case (i)
         6'd0:  inv_tbl = 5'd20;
         6'd1:  inv_tbl = 5'd22;
         6'd2:  inv_tbl = 5'd24;
         6'd3:  inv_tbl = 5'd6;
         6'd4:  inv_tbl = 5'd0;
         6'd5:  inv_tbl = 5'd3;
         6'd6:  inv_tbl = 5'd5;
         6'd7:  inv_tbl = 5'd15;
         6'd8:  inv_tbl = 5'd21;
         6'd9:  inv_tbl = 5'd25;
         6'd10: inv_tbl = 5'd1;
         6'd11: inv_tbl = 5'd4;
         6'd12: inv_tbl = 5'd2;
         6'd13: inv_tbl = 5'd10;
         6'd14: inv_tbl = 5'd12;
         6'd15: inv_tbl = 5'd19;
         6'd16: inv_tbl = 5'd7;
         6'd17: inv_tbl = 5'd23;
         6'd18: inv_tbl = 5'd18;
         6'd19: inv_tbl = 5'd11;
         6'd20: inv_tbl = 5'd17;
         6'd21: inv_tbl = 5'd8;
         6'd22: inv_tbl = 5'd13;
         6'd23: inv_tbl = 5'd16;
         6'd24: inv_tbl = 5'd14;
         6'd25: inv_tbl = 5'd9;
         default: inv_tbl = 5'd0;
      endcase
   endfunction
`endif

   logic [5:0] sum;
   logic [5:0] idx;
   logic [4:0] sub;
   logic [5:0] diff;
   logic [4:0] result;
   logic       illegal;

   always_comb begin
      illegal = (data_in >= 5'd26) || (position >= 5'd26);
      sum     = {1'b0, data_in} + {1'b0, position};
      idx     = (sum >= 6'd26) ? (sum - 6'd26) : sum;
`ifdef ROTOR0_REVERSE_EN
      sub     = reverse ? inv_tbl(idx) : fwd_tbl(idx);
`else
      sub     = fwd_tbl(idx);
`endif
      // diff[5] is the sign; adding 26 modulo 32 gives the wrapped letter
      diff    = {1'b0, sub} - {1'b0, position};
      result  = diff[5] ? (diff[4:0] + 5'd26) : diff[4:0];
      if (illegal) begin
         result = 5'd31;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_out  <= 5'd0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            data_out <= result;
         end
      end
   end

endmodule

// File: tb/tb_rotor_0.sv
// Self-checking bench for rotor_0 using a scoreboard queue of expected outputs.
module tb_rotor_0;

   typedef struct packed {
      logic       vld;
      logic [4:0] dat;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [4:0] data_in;
   logic [4:0] position;
`ifdef ROTOR0_REVERSE_EN
   logic       reverse;
`endif
   logic       out_valid;
   logic [4:0] data_out;

   int   errors;
   int   checks;
   exp_t sb[$];
   int   w_m [0:25];
   int   winv_m [0:25];

   rotor_0 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .position  (position),
`ifdef ROTOR0_REVERSE_EN
      .reverse   (reverse),
`endif
      .out_valid (out_valid),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model(input int d, input int p, input bit rev);
      int i;
      int v;
      if (d >= 26 || p >= 26) return 31;
      i = (d + p) % 26;
      v = rev ? winv_m[i] : w_m[i];
      return (v + 26 - p) % 26;
   endfunction

   // Drive one cycle, push its expected result, then pop and compare after the edge.
   task automatic send(input string name, input bit v, input int d, input int p,
                       input bit rev, input int exp_dat);
      exp_t e;
      exp_t got;
      @(negedge clk);
      in_valid = v;
      data_in  = 5'(d);
      position = 5'(p);
`ifdef ROTOR0_REVERSE_EN
      reverse  = rev;
`endif
      e.vld = v;
      e.dat = 5'(exp_dat);
      sb.push_back(e);
      @(posedge clk);
      #1;
      got.vld = out_valid;
      got.dat = data_out;
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s: out_valid=%0b data_out=%0d, expected out_valid=%0b data_out=%0d",
                  name, got.vld, got.dat, e.vld, e.dat);
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || data_out !== 5'd0) begin
         errors++;
         $display("FAIL reset_async: out_valid=%0b data_out=%0d, expected 0/0", out_valid, data_out);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_forward();
      int vec [7][3] = '{'{12, 10, 17}, '{3, 2, 4}, '{6, 1, 15}, '{7, 0, 16},
                         '{7, 1, 20}, '{8, 1, 24}, '{1, 1, 11}};
      for (int k = 0; k < 7; k++) begin
         send("forward", 1'b1, vec[k][0], vec[k][1], 1'b0, vec[k][2]);
      end
   endtask

   task automatic test_wrap_hold();
      send("wrap_25_25", 1'b1, 25, 25, 1'b0, 3);
      send("hold_invalid", 1'b0, 4, 9, 1'b0, 3);
      send("hold_invalid2", 1'b0, 0, 0, 1'b0, 3);
   endtask

   task automatic test_illegal();
      send("illegal_data", 1'b1, 26, 0, 1'b0, 31);
      send("illegal_pos", 1'b1, 0, 30, 1'b0, 31);
      send("illegal_both", 1'b1, 31, 31, 1'b0, 31);
   endtask

   task automatic test_back_to_back();
      for (int p = 0; p < 26; p++) begin
         for (int d = 0; d < 26; d++) begin
            send("b2b_forward", 1'b1, d, p, 1'b0, model(d, p, 1'b0));
         end
      end
   endtask

`ifdef ROTOR0_REVERSE_EN
   task automatic test_reverse();
      int f;
      send("reverse_17_10", 1'b1, 17, 10, 1'b1, 12);
      for (int p = 0; p < 26; p++) begin
         for (int d = 0; d < 26; d++) begin
            f = model(d, p, 1'b0);
            send("rev_fwd", 1'b1, d, p, 1'b0, f);
            send("rev_roundtrip", 1'b1, f, p, 1'b1, d);
         end
      end
   endtask
`endif

   task automatic test_reset_midstream();
      send("pre_reset", 1'b1, 5, 3, 1'b0, model(5, 3, 1'b0));
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || data_out !== 5'd0) begin
         errors++;
         $display("FAIL reset_midstream: out_valid=%0b data_out=%0d, expected 0/0", out_valid, data_out);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      send("post_reset", 1'b1, 7, 0, 1'b0, 16);
   endtask

   initial begin
      int wt [26] = '{4, 10, 12, 5, 11, 6, 3, 16, 21, 25, 13, 19, 14, 22, 24,
                      7, 23, 20, 18, 15, 0, 8, 1, 17, 2, 9};
      errors   = 0;
      checks   = 0;
      rst      = 1'b0;
      in_valid = 1'b0;
      data_in  = 5'd0;
      position = 5'd0;
`ifdef ROTOR0_REVERSE_EN
      reverse  = 1'b0;
`endif
      for (int i = 0; i < 26; i++) begin
         w_m[i]        = wt[i];
         winv_m[wt[i]] = i;
      end

      test_reset();
      test_forward();
      test_wrap_hold();
      test_illegal();
      test_back_to_back();
`ifdef ROTOR0_REVERSE_EN
      test_reverse();
`endif
      test_reset_midstream();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
